// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-cache memory port arbiter.
//   arb_state_e : arbiter FSM states (idle, serving I, serving D, dead release cycle)
//   side_e      : identifies a requesting cache side (I_cache or D_cache)
//   ADDR_W_DEF / DATA_W_DEF : default line address and line data widths
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter between the I_cache and D_cache request lines.
//   req_i, req_d : level requests from each side
//   last_grant   : side that completed the most recent transaction
//   rr_en        : 1 = alternate on a tie, 0 = D always wins a tie
//   gnt_i, gnt_d : one-hot grant, or none when nobody requests
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic  req_i,
    input  logic  req_d,
    input  side_e last_grant,
    input  logic  rr_en,
    output logic  gnt_i,
    output logic  gnt_d
);

    // Grant selection; a tie goes to the side that was not served last when rr_en is set.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
            if (rr_en && (last_grant == SIDE_D)) begin
                gnt_i = 1'b1;
            end else begin
                gnt_d = 1'b1;
            end
        end else if (req_d) begin
            gnt_d = 1'b1;
        end else if (req_i) begin
            gnt_i = 1'b1;
        end else begin
            gnt_i = 1'b0;
            gnt_d = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between the I_cache and D_cache line interfaces.
// One 128-bit line transaction is granted at a time; the winner's command is latched
// into registered strobe/address/data outputs and held until the memory answers.
//   clk, rst_n                   : clock, synchronous active-low reset
//   mem_read_X / mem_write_X     : level requests from cache side X (I or D)
//   mem_addr_X / mem_wdata_X     : line address / write line from side X
//   mem_rdata_X / mem_ready_X    : read line and completion back to side X
//   mem_read / mem_write         : registered memory strobes
//   mem_addr / mem_wdata         : registered memory address / write line
//   mem_rdata / mem_ready        : memory read line and 1-cycle completion pulse
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit RR_EN  = 1'b1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_I,
    input  logic              mem_write_I,
    input  logic [ADDR_W-1:0] mem_addr_I,
    input  logic [DATA_W-1:0] mem_wdata_I,
    output logic [DATA_W-1:0] mem_rdata_I,
    output logic              mem_ready_I,
    input  logic              mem_read_D,
    input  logic              mem_write_D,
    input  logic [ADDR_W-1:0] mem_addr_D,
    input  logic [DATA_W-1:0] mem_wdata_D,
    output logic [DATA_W-1:0] mem_rdata_D,
    output logic              mem_ready_D,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_r,      state_nxt_s;
    side_e             last_grant_r, last_grant_nxt_s;
    logic              read_r,       read_nxt_s;
    logic              write_r,      write_nxt_s;
    logic [ADDR_W-1:0] addr_r,       addr_nxt_s;
    logic [DATA_W-1:0] wdata_r,      wdata_nxt_s;

    logic req_i_s;
    logic req_d_s;
    logic gnt_i_s;
    logic gnt_d_s;

    assign req_i_s = mem_read_I | mem_write_I;
    assign req_d_s = mem_read_D | mem_write_D;

    rr_arb2 u_rr_arb2 (
        .req_i      (req_i_s),
        .req_d      (req_d_s),
        .last_grant (last_grant_r),
        .rr_en      (RR_EN),
        .gnt_i      (gnt_i_s),
        .gnt_d      (gnt_d_s)
    );

    // Next-state and next-command logic; grants are only taken in IDLE, and a write
    // request wins over a read request raised by the same side.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        read_nxt_s       = read_r;
        write_nxt_s      = write_r;
        addr_nxt_s       = addr_r;
        wdata_nxt_s      = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_d_s) begin
                    state_nxt_s = ST_SERVE_D;
                    write_nxt_s = mem_write_D;
                    read_nxt_s  = ~mem_write_D;
                    addr_nxt_s  = mem_addr_D;
                    wdata_nxt_s = mem_wdata_D;
                end else if (gnt_i_s) begin
                    state_nxt_s = ST_SERVE_I;
                    write_nxt_s = mem_write_I;
                    read_nxt_s  = ~mem_write_I;
                    addr_nxt_s  = mem_addr_I;
                    wdata_nxt_s = mem_wdata_I;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVE_I: begin
                if (mem_ready) begin
                    state_nxt_s      = ST_RELEASE;
                    last_grant_nxt_s = SIDE_I;
                    read_nxt_s       = 1'b0;
                    write_nxt_s      = 1'b0;
                end else begin
                    state_nxt_s = ST_SERVE_I;
                end
            end
            ST_SERVE_D: begin
                if (mem_ready) begin
                    state_nxt_s      = ST_RELEASE;
                    last_grant_nxt_s = SIDE_D;
                    read_nxt_s       = 1'b0;
                    write_nxt_s      = 1'b0;
                end else begin
                    state_nxt_s = ST_SERVE_D;
                end
            end
            ST_RELEASE: begin
                // Dead cycle so the served cache can drop its request before re-arbitration.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                read_nxt_s  = 1'b0;
                write_nxt_s = 1'b0;
            end
        endcase
    end

    // State and latched command registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= SIDE_I;
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            read_r       <= read_nxt_s;
            write_r      <= write_nxt_s;
            addr_r       <= addr_nxt_s;
            wdata_r      <= wdata_nxt_s;
        end
    end

    assign mem_read  = read_r;
    assign mem_write = write_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

    // Completion is forwarded combinationally, and only to the side being served;
    // read data fans out to both caches and is qualified by ready alone.
    assign mem_ready_I = (state_r == ST_SERVE_I) & mem_ready;
    assign mem_ready_D = (state_r == ST_SERVE_D) & mem_ready;
    assign mem_rdata_I = mem_rdata;
    assign mem_rdata_D = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          read_I = 1'b0, write_I = 1'b0, read_D = 1'b0, write_D = 1'b0;
    logic [AW-1:0] addr_I = '0, addr_D = '0;
    logic [DW-1:0] wdata_I = '0, wdata_D = '0, mem_rdata = '0;
    logic          mem_ready = 1'b0;

    logic          o0_ready_I, o0_ready_D, o0_read, o0_write;
    logic [DW-1:0] o0_rdata_I, o0_rdata_D, o0_wdata;
    logic [AW-1:0] o0_addr;
    logic          o1_ready_I, o1_ready_D, o1_read, o1_write;
    logic [DW-1:0] o1_rdata_I, o1_rdata_D, o1_wdata;
    logic [AW-1:0] o1_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_read_I(read_I), .mem_write_I(write_I), .mem_addr_I(addr_I), .mem_wdata_I(wdata_I),
        .mem_rdata_I(o0_rdata_I), .mem_ready_I(o0_ready_I),
        .mem_read_D(read_D), .mem_write_D(write_D), .mem_addr_D(addr_D), .mem_wdata_D(wdata_D),
        .mem_rdata_D(o0_rdata_D), .mem_ready_D(o0_ready_D),
        .mem_read(o0_read), .mem_write(o0_write), .mem_addr(o0_addr), .mem_wdata(o0_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_read_I(read_I), .mem_write_I(write_I), .mem_addr_I(addr_I), .mem_wdata_I(wdata_I),
        .mem_rdata_I(o1_rdata_I), .mem_ready_I(o1_ready_I),
        .mem_read_D(read_D), .mem_write_D(write_D), .mem_addr_D(addr_D), .mem_wdata_D(wdata_D),
        .mem_rdata_D(o1_rdata_D), .mem_ready_D(o1_ready_D),
        .mem_read(o1_read), .mem_write(o1_write), .mem_addr(o1_addr), .mem_wdata(o1_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model, one copy per instance (index 0: fixed priority, 1: round-robin).
    // owner: 0 = nobody, 1 = I side, 2 = D side.
    int            m_owner [2] = '{0, 0};
    bit            m_rel   [2] = '{1'b0, 1'b0};
    bit            m_last  [2] = '{1'b0, 1'b0};
    bit            m_rd    [2] = '{1'b0, 1'b0};
    bit            m_wr    [2] = '{1'b0, 1'b0};
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    int            glog0[$];
    int            glog1[$];

    int rand_mode = 0;     // 0 directed, 1 random, 2 saturated
    int ref_m = 1;         // model whose completions drive the cache stand-ins
    bit sat_d_off = 1'b0;
    bit done_i = 1'b0, done_d = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step_model(input int m);
        bit reqi, reqd;
        int pick;
        if (!rst_n) begin
            m_owner[m] = 0; m_rel[m] = 1'b0; m_last[m] = 1'b0;
            m_rd[m] = 1'b0; m_wr[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
        end else if (m_owner[m] != 0) begin
            if (mem_ready) begin
                m_last[m]  = (m_owner[m] == 2);
                m_owner[m] = 0;
                m_rd[m] = 1'b0; m_wr[m] = 1'b0;
                m_rel[m] = 1'b1;
            end
        end else if (m_rel[m]) begin
            m_rel[m] = 1'b0;
        end else begin
            reqi = read_I | write_I;
            reqd = read_D | write_D;
            pick = 0;
            if (reqi && reqd) pick = (m == 1 && m_last[m]) ? 1 : 2;
            else if (reqd)    pick = 2;
            else if (reqi)    pick = 1;
            if (pick == 2) begin
                m_wr[m] = write_D; m_rd[m] = !write_D; m_addr[m] = addr_D; m_wdata[m] = wdata_D;
            end else if (pick == 1) begin
                m_wr[m] = write_I; m_rd[m] = !write_I; m_addr[m] = addr_I; m_wdata[m] = wdata_I;
            end
            if (pick != 0) begin
                m_owner[m] = pick;
                if (m == 0) glog0.push_back(pick); else glog1.push_back(pick);
            end
        end
    endtask

    task automatic compare_inst(input int m, input logic rI, input logic rD,
                                input logic [DW-1:0] dI, input logic [DW-1:0] dD,
                                input logic rd, input logic wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd);
        string p;
        p = (m == 1) ? "rr1" : "rr0";
        chk({p, "_mem_read"},    rd, m_rd[m]);
        chk({p, "_mem_write"},   wr, m_wr[m]);
        chk({p, "_ready_I"},     rI, (m_owner[m] == 1) && mem_ready);
        chk({p, "_ready_D"},     rD, (m_owner[m] == 2) && mem_ready);
        chk({p, "_rdata_I"},     dI, mem_rdata);
        chk({p, "_rdata_D"},     dD, mem_rdata);
        if (m_rd[m] || m_wr[m]) begin
            chk({p, "_mem_addr"},  a, m_addr[m]);
            chk({p, "_mem_wdata"}, wd, m_wdata[m]);
        end
    endtask

    task automatic gen_side(input bit is_d, input bit done, input bit sat, input bit off,
                            inout logic rd, inout logic wr,
                            inout logic [AW-1:0] a, inout logic [DW-1:0] wd);
        logic [31:0] r;
        if (done) begin
            rd = 1'b0; wr = 1'b0;
        end else if (!(rd || wr)) begin
            if (!off && (sat || $urandom_range(0, 3) == 0)) begin
                r = $urandom;
                case (r[1:0])
                    2'd0:    begin rd = 1'b0; wr = 1'b1; end
                    2'd1:    begin rd = 1'b1; wr = 1'b1; end
                    default: begin rd = 1'b1; wr = 1'b0; end
                endcase
                r = $urandom;
                a = {is_d, r[AW-2:0]};
                wd = {$urandom, $urandom, $urandom, $urandom};
            end
        end else if (!sat) begin
            r = $urandom;
            if (r[3:0] == 4'd0) begin
                rd = 1'b0; wr = 1'b0;
            end else if (r[6:4] == 3'd0) begin
                r = $urandom;
                a = {is_d, r[AW-2:0]};
            end
        end
    endtask

    task automatic gen_inputs();
        bit sat;
        sat = (rand_mode == 2);
        gen_side(1'b0, done_i, sat, 1'b0, read_I, write_I, addr_I, wdata_I);
        gen_side(1'b1, done_d, sat, sat_d_off, read_D, write_D, addr_D, wdata_D);
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (!sat) rst_n = ($urandom_range(0, 199) != 0);
        else      rst_n = 1'b1;
    endtask

    // One clock: advance models on the edge, drive, then compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        done_i = rst_n && mem_ready && (m_owner[ref_m] == 1);
        done_d = rst_n && mem_ready && (m_owner[ref_m] == 2);
        step_model(0);
        step_model(1);
        #1;
        if (rand_mode != 0) gen_inputs();
        #4;
        compare_inst(0, o0_ready_I, o0_ready_D, o0_rdata_I, o0_rdata_D, o0_read, o0_write, o0_addr, o0_wdata);
        compare_inst(1, o1_ready_I, o1_ready_D, o1_rdata_I, o1_rdata_D, o1_read, o1_write, o1_addr, o1_wdata);
    endtask

    task automatic do_reset();
        rand_mode = 0;
        rst_n = 1'b0;
        read_I = 1'b0; write_I = 1'b0; read_D = 1'b0; write_D = 1'b0;
        mem_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        int first_i;

        // Reset state
        do_reset();
        chk("reset_read", o1_read, 1'b0);
        chk("reset_write", o1_write, 1'b0);
        chk("reset_addr", o1_addr, 28'h0);
        chk("reset_wdata", o1_wdata, 128'h0);

        // 1: single D read, memory answers 5 cycles after the grant edge
        read_D = 1'b1; addr_D = 28'h1234567;
        cycle();
        chk("t1_read", o1_read, 1'b1);
        chk("t1_write", o1_write, 1'b0);
        chk("t1_addr", o1_addr, 28'h1234567);
        repeat (4) cycle();
        mem_ready = 1'b1; mem_rdata = {16{8'hA5}};
        #1;
        chk("t1_ready_D", o1_ready_D, 1'b1);
        chk("t1_ready_I", o1_ready_I, 1'b0);
        chk("t1_rdata_D", o1_rdata_D, {16{8'hA5}});
        cycle();  // now RELEASE, mem_ready still high: spurious there
        chk("t6_release_ready_D", o1_ready_D, 1'b0);
        chk("t1_strobe_cleared", o1_read, 1'b0);
        read_D = 1'b0; mem_ready = 1'b0;
        cycle();

        // 2: simultaneous I read and D write after reset
        do_reset();
        read_I = 1'b1; addr_I = 28'h0000AAA;
        write_D = 1'b1; addr_D = 28'h8000BBB; wdata_D = {4{32'hDEADBEEF}};
        cycle();
        chk("t2_d_write", o1_write, 1'b1);
        chk("t2_d_noread", o1_read, 1'b0);
        chk("t2_d_addr", o1_addr, 28'h8000BBB);
        chk("t2_d_wdata", o1_wdata, {4{32'hDEADBEEF}});
        cycle();
        mem_ready = 1'b1;
        #1;
        chk("t2_ready_D", o1_ready_D, 1'b1);
        chk("t2_ready_I", o1_ready_I, 1'b0);
        cycle();
        write_D = 1'b0; mem_ready = 1'b0;
        chk("t2_release_write", o1_write, 1'b0);
        chk("t2_release_read", o1_read, 1'b0);
        cycle();
        chk("t2_idle_read", o1_read, 1'b0);
        cycle();
        chk("t2_i_read", o1_read, 1'b1);
        chk("t2_i_addr", o1_addr, 28'h0000AAA);
        mem_ready = 1'b1;
        #1;
        chk("t2_ready_I", o1_ready_I, 1'b1);
        cycle();
        read_I = 1'b0; mem_ready = 1'b0;
        cycle();

        // 4: I request dropped while being served
        do_reset();
        read_I = 1'b1; addr_I = 28'h0555555;
        cycle();
        cycle();
        read_I = 1'b0;
        cycle();
        chk("t4_held_1", o1_read, 1'b1);
        cycle();
        chk("t4_held_2", o1_read, 1'b1);
        mem_ready = 1'b1; read_D = 1'b1; addr_D = 28'h8111111;
        #1;
        chk("t4_ready_I", o1_ready_I, 1'b1);
        cycle();
        mem_ready = 1'b0;
        chk("t4_release_no_grant", o1_read, 1'b0);
        cycle();
        chk("t4_idle_no_strobe", o1_read, 1'b0);
        cycle();
        chk("t4_d_granted", o1_read, 1'b1);
        chk("t4_d_addr", o1_addr, 28'h8111111);
        mem_ready = 1'b1;
        cycle();
        read_D = 1'b0; mem_ready = 1'b0;
        cycle();

        // 5: reset during SERVE_D, then a stray mem_ready in IDLE
        do_reset();
        read_D = 1'b1; addr_D = 28'h8222222; wdata_D = {4{32'h12345678}};
        cycle();
        cycle();
        chk("t5_serving", o1_read, 1'b1);
        rst_n = 1'b0;
        cycle();
        chk("t5_rst_read", o1_read, 1'b0);
        chk("t5_rst_addr", o1_addr, 28'h0);
        chk("t5_rst_wdata", o1_wdata, 128'h0);
        chk("t5_rst_ready_D", o1_ready_D, 1'b0);
        rst_n = 1'b1; read_D = 1'b0;
        cycle();
        mem_ready = 1'b1;
        #1;
        chk("t6_idle_ready_D", o1_ready_D, 1'b0);
        chk("t6_idle_ready_I", o1_ready_I, 1'b0);
        cycle();
        chk("t6_idle_no_grant", o1_read | o1_write, 1'b0);
        mem_ready = 1'b0;
        cycle();

        // 3a: both sides saturated, round-robin instance
        do_reset();
        glog0.delete(); glog1.delete();
        ref_m = 1; sat_d_off = 1'b0; rand_mode = 2;
        budget = 0;
        while (glog1.size() < 6 && budget < 600) begin
            cycle();
            budget++;
        end
        chk("t3_rr1_count", (glog1.size() >= 6), 1'b1);
        if (glog1.size() >= 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("t3_rr1_grant%0d", k), glog1[k], (k % 2 == 0) ? 2 : 1);
        end

        // 3b: both saturated, fixed-priority instance; I only once D goes quiet
        do_reset();
        glog0.delete(); glog1.delete();
        ref_m = 0; sat_d_off = 1'b0; rand_mode = 2;
        budget = 0;
        while (glog0.size() < 6 && budget < 600) begin
            cycle();
            budget++;
        end
        chk("t3_rr0_count", (glog0.size() >= 6), 1'b1);
        for (int k = 0; k < glog0.size(); k++) chk($sformatf("t3_rr0_grant%0d", k), glog0[k], 2);
        sat_d_off = 1'b1;
        first_i = -1;
        budget = 0;
        while (first_i < 0 && budget < 600) begin
            cycle();
            budget++;
            for (int k = 0; k < glog0.size(); k++) if (first_i < 0 && glog0[k] == 1) first_i = k;
        end
        chk("t3_rr0_i_granted", (first_i >= 0), 1'b1);
        chk("t3_rr0_i_after_d", (first_i >= 6), 1'b1);
        sat_d_off = 1'b0;

        // Random traffic with spurious ready pulses, drops and occasional resets
        do_reset();
        ref_m = 1; rand_mode = 1;
        repeat (3000) cycle();
        rand_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
